atpg_response_checker: RTL and testbench

On-chip capture/compare end of the two-pattern (launch-on-capture) ATPG flow: the pattern applier drives initialisation and launch vectors into the circuit under test, and this block strobes the single-bit response a fixed number of cycles after each launch. It compares the sample against a streamed expected value and accumulates a fail count, the first failing pattern index and a MISR signature. It sits beside the fault-injection wrapper and replaces the file-based response dump for self-checking runs.

---
 rtl/atpg_pkg.sv | 16 +
 rtl/atpg_response_checker_if.sv | 31 +++
 rtl/atpg_misr.sv | 34 +++
 rtl/atpg_response_checker.sv | 120 ++++++++++++
 tb/tb_atpg_response_checker.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/atpg_pkg.sv
// rtl/atpg_pkg.sv - shared state encoding and defaults for the ATPG response checker
package atpg_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WAIT    = 3'd1;
  localparam logic [2:0] ST_SETTLE  = 3'd2;
  localparam logic [2:0] ST_COMPARE = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  localparam logic [15:0] DEF_SIG_POLY = 16'h1021;
  localparam logic [15:0] DEF_SIG_SEED = 16'hFFFF;

  // Sliced to the pattern-index width by users; all-ones marks "no failure seen".
  localparam logic [63:0] NO_FAIL_IDX = '1;

endpackage

// File: rtl/atpg_response_checker_if.sv
// rtl/atpg_response_checker_if.sv - run control, response/expected stream and result bundle
interface atpg_response_checker_if #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  parameter int SIG_W = 16
);
  logic             start;
  logic [PAT_W-1:0] num_patterns;
  logic             launch;
  logic             y;
  logic             exp_valid;
  logic             exp_y;
  logic             exp_ready;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] fail_count;
  logic [PAT_W-1:0] first_fail_idx;
  logic [SIG_W-1:0] signature;
  logic             proto_err;

  modport master (
    output start, num_patterns, launch, y, exp_valid, exp_y,
    input  exp_ready, busy, done, pass, fail_count, first_fail_idx, signature, proto_err
  );

  modport slave (
    input  start, num_patterns, launch, y, exp_valid, exp_y,
    output exp_ready, busy, done, pass, fail_count, first_fail_idx, signature, proto_err
  );
endinterface

// File: rtl/atpg_misr.sv
// rtl/atpg_misr.sv - serial-input MISR with seed load and shift enable
module atpg_misr
  import atpg_pkg::*;
#(
  parameter int               SIG_W    = 16,
  parameter logic [SIG_W-1:0] SIG_POLY = DEF_SIG_POLY,
  parameter logic [SIG_W-1:0] SIG_SEED = DEF_SIG_SEED
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_seed,
  input  logic             en,
  input  logic             din,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] sig_next;

  always_comb begin
    sig_next = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? SIG_POLY : '0);
    sig_next[0] = sig_next[0] ^ din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= SIG_SEED;
    end else if (load_seed) begin
      sig <= SIG_SEED;
    end else if (en) begin
      sig <= sig_next;
    end
  end

endmodule

// File: rtl/atpg_response_checker.sv
// rtl/atpg_response_checker.sv - strobes the CUT response after each launch and compares it
module atpg_response_checker
  import atpg_pkg::*;
#(
  parameter int               PAT_W      = 8,
  parameter int unsigned      SETTLE_CYC = 1,
  parameter int               CNT_W      = 8,
  parameter int               SIG_W      = 16,
  parameter logic [SIG_W-1:0] SIG_POLY   = DEF_SIG_POLY,
  parameter logic [SIG_W-1:0] SIG_SEED   = DEF_SIG_SEED
) (
  input  logic                  clk,
  input  logic                  rst_n,
  atpg_response_checker_if.slave bus
);

  localparam logic [PAT_W-1:0] NO_FAIL     = NO_FAIL_IDX[PAT_W-1:0];
  localparam logic [PAT_W-1:0] ONE_P       = 1;
  localparam logic [CNT_W-1:0] ONE_C       = 1;
  localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYC - 1);

  logic [2:0]       state;
  logic [PAT_W-1:0] idx;
  logic [PAT_W-1:0] pat_cnt;
  logic [PAT_W-1:0] first_fail_idx;
  logic [3:0]       settle_cnt;
  logic             cap_y;
  logic             proto_err;
  logic [CNT_W-1:0] fail_count;
  logic             start_acc;
  logic             cmp_fire;
  logic             mismatch;
  logic             last_pat;

  assign start_acc = bus.start && (state == ST_IDLE || state == ST_DONE);
  assign cmp_fire  = (state == ST_COMPARE) && bus.exp_valid;
  assign mismatch  = cap_y ^ bus.exp_y;
  assign last_pat  = (idx == pat_cnt - ONE_P);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      idx            <= '0;
      pat_cnt        <= '0;
      settle_cnt     <= '0;
      cap_y          <= 1'b0;
      fail_count     <= '0;
      first_fail_idx <= NO_FAIL;
      proto_err      <= 1'b0;
    end else begin
      // A stray launch never steers the FSM; it only leaves a sticky flag.
      if (bus.launch && state != ST_WAIT) begin
        proto_err <= 1'b1;
      end
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            pat_cnt        <= bus.num_patterns;
            idx            <= '0;
            fail_count     <= '0;
            first_fail_idx <= NO_FAIL;
            proto_err      <= 1'b0;
            state          <= (bus.num_patterns == '0) ? ST_DONE : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.launch) begin
            settle_cnt <= SETTLE_LOAD;
            state      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt != 4'd0) begin
            settle_cnt <= settle_cnt - 4'd1;
          end else begin
            cap_y <= bus.y;
            state <= ST_COMPARE;
          end
        end
        ST_COMPARE: begin
          if (bus.exp_valid) begin
            if (mismatch) begin
              if (fail_count != '1) fail_count <= fail_count + ONE_C;
              if (first_fail_idx == NO_FAIL) first_fail_idx <= idx;
            end
            if (last_pat) begin
              state <= ST_DONE;
            end else begin
              idx   <= idx + ONE_P;
              state <= ST_WAIT;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  atpg_misr #(
    .SIG_W   (SIG_W),
    .SIG_POLY(SIG_POLY),
    .SIG_SEED(SIG_SEED)
  ) u_misr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_seed(start_acc),
    .en       (cmp_fire),
    .din      (cap_y),
    .sig      (bus.signature)
  );

  assign bus.exp_ready      = (state == ST_COMPARE);
  assign bus.busy           = (state == ST_WAIT) || (state == ST_SETTLE) || (state == ST_COMPARE);
  assign bus.done           = (state == ST_DONE);
  assign bus.pass           = (state == ST_DONE) && (fail_count == '0);
  assign bus.fail_count     = fail_count;
  assign bus.first_fail_idx = first_fail_idx;
  assign bus.proto_err      = proto_err;

endmodule

// File: tb/tb_atpg_response_checker.sv
// tb/tb_atpg_response_checker.sv - directed scoreboard bench for atpg_response_checker
module tb_atpg_response_checker;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  atpg_response_checker_if #(.PAT_W(8), .CNT_W(8), .SIG_W(16)) ifa ();
  atpg_response_checker_if #(.PAT_W(8), .CNT_W(2), .SIG_W(16)) ifb ();

  atpg_response_checker #(.SETTLE_CYC(1)) dut_a (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifa)
  );

  atpg_response_checker #(.SETTLE_CYC(3), .CNT_W(2)) dut_b (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifb)
  );

  typedef struct {
    logic [7:0]  fails;
    logic [7:0]  first;
    logic [15:0] sig;
    logic        pass;
  } res_t;

  res_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic d);
    logic [15:0] n;
    n = {s[14:0], 1'b0};
    if (s[15]) n = n ^ 16'h1021;
    n[0] = n[0] ^ d;
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_sb(input string tag, input logic dn, input logic ps,
                          input logic [7:0] fc, input logic [7:0] ff, input logic [15:0] sg);
    res_t r;
    check({tag, "_sb_avail"}, 32'(sb.size()), 32'd1);
    if (sb.size() == 0) return;
    r = sb.pop_front();
    check({tag, "_done"}, 32'(dn), 32'd1);
    check({tag, "_pass"}, 32'(ps), 32'(r.pass));
    check({tag, "_fail_count"}, 32'(fc), 32'(r.fails));
    check({tag, "_first_fail"}, 32'(ff), 32'(r.first));
    check({tag, "_signature"}, 32'(sg), 32'(r.sig));
  endtask

  task automatic push_model(input int n, input logic [15:0] yb, input logic [15:0] eb, input int sat);
    res_t        r;
    logic [15:0] s;
    int          fc;
    s = 16'hFFFF;
    fc = 0;
    r.first = 8'hFF;
    for (int i = 0; i < n; i++) begin
      s = misr_step(s, yb[i]);
      if (yb[i] != eb[i]) begin
        if (fc == 0) r.first = 8'(i);
        fc++;
      end
    end
    r.fails = 8'((fc > sat) ? sat : fc);
    r.sig   = s;
    r.pass  = (fc == 0);
    sb.push_back(r);
  endtask

  task automatic apply_a(input logic yv, input logic ev, input int stall, input bit proto);
    int n;
    n = 0;
    @(negedge clk);
    ifa.launch = 1'b1;
    ifa.y      = yv;
    @(negedge clk);
    ifa.launch = 1'b0;
    while (ifa.exp_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("a_ready", 32'(ifa.exp_ready), 32'd1);
    check("a_strobe_latency", 32'(n), 32'd1);
    ifa.y = ~yv;
    for (int s = 0; s < stall; s++) begin
      ifa.launch = proto && (s == 0);
      @(negedge clk);
      ifa.launch = 1'b0;
      check("a_stall_ready", 32'(ifa.exp_ready), 32'd1);
      check("a_stall_busy", 32'(ifa.busy), 32'd1);
    end
    ifa.exp_valid = 1'b1;
    ifa.exp_y     = ev;
    @(negedge clk);
    ifa.exp_valid = 1'b0;
  endtask

  task automatic run_a(input string tag, input int n, input logic [15:0] yb, input logic [15:0] eb,
                       input int stall_at, input bit proto);
    push_model(n, yb, eb, 255);
    @(negedge clk);
    ifa.start        = 1'b1;
    ifa.num_patterns = 8'(n);
    @(negedge clk);
    ifa.start = 1'b0;
    for (int i = 0; i < n; i++) begin
      apply_a(yb[i], eb[i], (i == stall_at) ? 10 : 0, proto);
    end
    check_sb(tag, ifa.done, ifa.pass, ifa.fail_count, ifa.first_fail_idx, ifa.signature);
  endtask

  // y toggles every cycle after launch; only the value at launch edge + 3 is 1 when seen by exp.
  task automatic apply_b(input logic ev);
    @(negedge clk);
    ifb.launch = 1'b1;
    ifb.y      = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      ifb.launch = 1'b0;
      ifb.y      = k[0];
    end
    check("b_settle_not_ready", 32'(ifb.exp_ready), 32'd0);
    @(negedge clk);
    ifb.y = 1'b0;
    check("b_strobe_ready", 32'(ifb.exp_ready), 32'd1);
    ifb.exp_valid = 1'b1;
    ifb.exp_y     = ev;
    @(negedge clk);
    ifb.exp_valid = 1'b0;
  endtask

  task automatic run_b(input string tag, input int n, input logic [15:0] eb);
    push_model(n, 16'hFFFF, eb, 3);
    @(negedge clk);
    ifb.start        = 1'b1;
    ifb.num_patterns = 8'(n);
    @(negedge clk);
    ifb.start = 1'b0;
    for (int i = 0; i < n; i++) begin
      apply_b(eb[i]);
    end
    check_sb(tag, ifb.done, ifb.pass, 8'(ifb.fail_count), ifb.first_fail_idx, ifb.signature);
  endtask

  initial begin
    rst_n = 1'b0;
    ifa.start = 1'b0; ifa.num_patterns = '0; ifa.launch = 1'b0;
    ifa.y = 1'b0; ifa.exp_valid = 1'b0; ifa.exp_y = 1'b0;
    ifb.start = 1'b0; ifb.num_patterns = '0; ifb.launch = 1'b0;
    ifb.y = 1'b0; ifb.exp_valid = 1'b0; ifb.exp_y = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_busy", 32'(ifa.busy), 32'd0);
    check("rst_done", 32'(ifa.done), 32'd0);
    check("rst_pass", 32'(ifa.pass), 32'd0);
    check("rst_exp_ready", 32'(ifa.exp_ready), 32'd0);
    check("rst_proto_err", 32'(ifa.proto_err), 32'd0);
    check("rst_fail_count", 32'(ifa.fail_count), 32'd0);
    check("rst_first_fail", 32'(ifa.first_fail_idx), 32'hFF);
    check("rst_signature", 32'(ifa.signature), 32'hFFFF);

    rst_n = 1'b1;
    @(negedge clk);

    run_a("allpass", 6, 16'b101101, 16'b101101, -1, 1'b0);
    check("allpass_proto_err", 32'(ifa.proto_err), 32'd0);

    run_a("fail24", 6, 16'b111001, 16'b101101, -1, 1'b0);
    check("fail24_count_const", 32'(ifa.fail_count), 32'd2);
    check("fail24_first_const", 32'(ifa.first_fail_idx), 32'd2);

    run_a("stall", 3, 16'b011, 16'b001, 1, 1'b0);
    check("stall_proto_err", 32'(ifa.proto_err), 32'd0);

    run_a("proto", 2, 16'b10, 16'b10, 0, 1'b1);
    check("proto_err_set", 32'(ifa.proto_err), 32'd1);

    run_a("zero", 0, 16'b0, 16'b0, -1, 1'b0);
    check("zero_busy", 32'(ifa.busy), 32'd0);
    check("zero_proto_cleared", 32'(ifa.proto_err), 32'd0);

    run_b("strobe3", 4, 16'b0101);
    run_b("sat5", 6, 16'b100000);
    check("sat5_count_const", 32'(ifb.fail_count), 32'd3);

    // reset while the second pattern of a run is settling
    @(negedge clk);
    ifa.start        = 1'b1;
    ifa.num_patterns = 8'd3;
    @(negedge clk);
    ifa.start = 1'b0;
    apply_a(1'b1, 1'b0, 0, 1'b0);
    check("mid_fail_before_rst", 32'(ifa.fail_count), 32'd1);
    @(negedge clk);
    ifa.launch = 1'b1;
    @(negedge clk);
    ifa.launch = 1'b0;
    check("mid_busy_before_rst", 32'(ifa.busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(ifa.busy), 32'd0);
    check("mid_rst_done", 32'(ifa.done), 32'd0);
    check("mid_rst_pass", 32'(ifa.pass), 32'd0);
    check("mid_rst_exp_ready", 32'(ifa.exp_ready), 32'd0);
    check("mid_rst_fail_count", 32'(ifa.fail_count), 32'd0);
    check("mid_rst_first_fail", 32'(ifa.first_fail_idx), 32'hFF);
    check("mid_rst_signature", 32'(ifa.signature), 32'hFFFF);
    check("mid_rst_proto_err", 32'(ifa.proto_err), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
